// File: rtl/sd_resp_rx_ctrl.sv
// rtl/sd_resp_rx_ctrl.sv - sequences the CMD-line deserializer for one SD card response
module sd_resp_rx_ctrl #(
    parameter int TIMEOUT      = 64,
    parameter int BITS_COUNTER = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    long_resp,
    input  logic                    check_crc,
    input  logic                    cmd_in,
    output logic                    deser_reset,
    output logic                    deser_enable,
    output logic [BITS_COUNTER-1:0] deser_framesize,
    output logic                    busy,
    output logic                    done,
    output logic                    timeout_err,
    output logic                    crc_err,
    output logic                    end_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RECV = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [BITS_COUNTER-1:0] L_SHORT     = BITS_COUNTER'(48);
    localparam logic [BITS_COUNTER-1:0] L_LONG      = BITS_COUNTER'(136);
    localparam logic [BITS_COUNTER-1:0] L_FEED_LO_L = BITS_COUNTER'(8);
    localparam logic [BITS_COUNTER-1:0] L_FEED_HI_S = BITS_COUNTER'(39);
    localparam logic [BITS_COUNTER-1:0] L_FEED_HI_L = BITS_COUNTER'(127);
    localparam logic [BITS_COUNTER-1:0] L_LAST_S    = BITS_COUNTER'(47);
    localparam logic [BITS_COUNTER-1:0] L_LAST_L    = BITS_COUNTER'(135);

    logic [1:0]              r_state;
    logic                    r_long;
    logic                    r_check;
    logic [TW-1:0]           r_to_cnt;
    logic [BITS_COUNTER-1:0] r_idx;
    logic [6:0]              r_crc;
    logic                    r_crc_bad;
    logic                    r_timeout_err;
    logic                    r_crc_err;
    logic                    r_end_err;
    logic [BITS_COUNTER-1:0] r_framesize;

    logic [TW-1:0]           w_to_next;
    logic                    w_crc_fb;
    logic [6:0]              w_crc_next;
    logic [BITS_COUNTER-1:0] w_feed_lo;
    logic [BITS_COUNTER-1:0] w_feed_hi;
    logic [BITS_COUNTER-1:0] w_last;
    logic                    w_in_feed;
    logic                    w_in_cmp;
    logic                    w_accept;

    assign w_accept   = (r_state == S_IDLE) && start;
    assign w_to_next  = r_to_cnt + 1'b1;
    assign w_crc_fb   = cmd_in ^ r_crc[6];
    assign w_crc_next = {r_crc[5:0], 1'b0} ^ (w_crc_fb ? 7'h09 : 7'h00);

    // Long (R2) frames exclude the start/transmission/reserved byte from the CRC.
    assign w_feed_lo = r_long ? L_FEED_LO_L : '0;
    assign w_feed_hi = r_long ? L_FEED_HI_L : L_FEED_HI_S;
    assign w_last    = r_long ? L_LAST_L    : L_LAST_S;
    assign w_in_feed = (r_idx >= w_feed_lo) && (r_idx <= w_feed_hi);
    assign w_in_cmp  = (r_idx > w_feed_hi) && (r_idx < w_last);

    assign deser_reset     = reset | w_accept;
    assign deser_enable    = (r_state == S_RECV) || ((r_state == S_WAIT) && !cmd_in);
    assign deser_framesize = r_framesize;
    assign busy            = (r_state != S_IDLE);
    assign done            = (r_state == S_DONE);
    assign timeout_err     = r_timeout_err;
    assign crc_err         = r_crc_err;
    assign end_err         = r_end_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_long        <= 1'b0;
            r_check       <= 1'b0;
            r_to_cnt      <= '0;
            r_idx         <= '0;
            r_crc         <= '0;
            r_crc_bad     <= 1'b0;
            r_timeout_err <= 1'b0;
            r_crc_err     <= 1'b0;
            r_end_err     <= 1'b0;
            r_framesize   <= L_SHORT;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_long        <= long_resp;
                        r_check       <= check_crc;
                        r_framesize   <= long_resp ? L_LONG : L_SHORT;
                        r_to_cnt      <= '0;
                        r_timeout_err <= 1'b0;
                        r_crc_err     <= 1'b0;
                        r_end_err     <= 1'b0;
                        r_state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!cmd_in) begin
                        // Start bit is 0, so feeding it into a zero CRC leaves it zero.
                        r_idx     <= BITS_COUNTER'(1);
                        r_crc     <= '0;
                        r_crc_bad <= 1'b0;
                        r_state   <= S_RECV;
                    end else if (w_to_next == TW'(TIMEOUT)) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= S_DONE;
                    end else begin
                        r_to_cnt <= w_to_next;
                    end
                end
                S_RECV: begin
                    if (w_in_feed) begin
                        r_crc <= w_crc_next;
                    end else if (w_in_cmp) begin
                        r_crc <= {r_crc[5:0], 1'b0};
                        if (cmd_in != r_crc[6]) r_crc_bad <= 1'b1;
                    end
                    if (r_idx == w_last) begin
                        r_end_err <= !cmd_in;
                        r_crc_err <= r_check & r_crc_bad;
                        r_state   <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/sd_resp_rx_ctrl.md
# sd_resp_rx_ctrl

Controller that sequences the command-line deserializer when the SD host receives a card response. After a command is sent, it waits for the response start bit on CMD. It then enables the deserializer for exactly 48 or 136 bits and computes CRC7 on the fly. It reports done with timeout, CRC and end-bit status. It sits between the command FSM, which issues `start`, and the shared deserializer instance, which it drives through `deser_*`.

## Interface
- TIMEOUT, 64: cycles to wait for the start bit (SD Ncr limit).
- BITS_COUNTER, 8: width of `deser_framesize` and of the internal bit index; must be ≥ 8.

- clk  in  1  CMD-line clock; `cmd_in` is sampled on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request to capture one response; sampled only in IDLE.
- long_resp  in  1  latched at start: 0 = 48-bit frame, 1 = 136-bit frame (R2).
- check_crc  in  1  latched at start: 0 disables CRC compare (R3).
- cmd_in  in  1  serial CMD line; the deserializer's data input is wired to the same net.
- deser_reset  out  1  combinational: `reset | (IDLE & start)`.
- deser_enable  out  1  combinational capture enable for the deserializer.
- deser_framesize  out  BITS_COUNTER  48 or 136 from latched `long_resp`; reset value 48.
- busy  out  1  `state != IDLE`.
- done  out  1  one-cycle pulse at end of transaction.
- timeout_err, crc_err, end_err  out  1 each  status flags, valid from the `done` cycle and held until the next accepted start.

## Operation
- States: IDLE, WAIT_START, RECEIVE, DONE.
- IDLE:
  - `start = 1` → latch `long_resp` and `check_crc`, clear all flags, clear the timeout counter, go to WAIT_START.
  - `deser_reset` is high in that same cycle.
- WAIT_START:
  - `cmd_in = 0` → `deser_enable = 1` in that cycle, capturing bit 0. Set the bit index to 1 and CRC to 0, then go to RECEIVE.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT, set `timeout_err` and go to DONE.
- RECEIVE:
  - `deser_enable = 1` every cycle; the bit index increments per cycle.
  - Exit after index framesize−1 is captured → DONE.
- CRC7:
  - Polynomial x^7+x^3+1, register initialised to 0, MSB-first.
  - 48-bit frame: CRC is fed bits 0..39 and compared with bits 40..46.
  - 136-bit frame: CRC is fed bits 8..127 and compared with bits 128..134.
  - Bit 0 is the start bit. For 48-bit frames the CRC input includes bit 0, which was captured in WAIT_START.
  - Mismatch with latched `check_crc = 1` → `crc_err`.
- End bit: bit framesize−1 must be 1; otherwise `end_err`.
- DONE: `done = 1` for one cycle, then IDLE.
- Ignored inputs:
  - `start` is ignored while `busy`.
  - `long_resp` and `check_crc` changes after acceptance are ignored.
- The start bit is not checked inside RECEIVE. Transmission and reserved bits are not checked.

## Timing
- Reset values: state IDLE, `done`/`busy`/all flags 0, `deser_framesize` 48, `deser_enable` 0.
- `start` accepted at cycle 0 → WAIT_START from cycle 1. `cmd_in` may already be 0 at cycle 1.
- Start bit sampled at cycle s:
  - bit k is captured at s+k;
  - the last bit is captured at s+47 (short) or s+135 (long);
  - `done` is at s+48 or s+136.
- Timeout: `cmd_in` held at 1 for cycles 1..TIMEOUT → `done` with `timeout_err` at cycle TIMEOUT+1; `deser_enable` is never asserted.
- A start bit at exactly cycle TIMEOUT is accepted, not a timeout.
- `busy` is high from cycle 1 through the `done` cycle inclusive.
- A new `start` is accepted at the earliest one cycle after `done`.
- Reset mid-operation returns to IDLE at the next edge. Flags and `done` are cleared, and `deser_reset` is high while `reset` is high.

## Test plan
- Short response, valid CRC: start with long_resp=0, check_crc=1. Drive 3 idle-high cycles, then frame 0x40_00000000, CRC 0x4A, end bit 1 (byte 0x95). → `done` at s+48, all flags 0, 48 `deser_enable` cycles.
- CRC error: same frame with the CRC field 0x4B → `done` with `crc_err = 1` and `end_err = 0`. Repeat with check_crc=0 → `crc_err = 0`.
- End-bit error and a second CRC vector: frame 0x48_000001AA, CRC 0x43, end bit 0 → `end_err = 1`, `crc_err = 0`.
- Timeout: start, `cmd_in` held at 1 → `done` at cycle 65 with `timeout_err = 1` and no `deser_enable` pulse. With the start bit at cycle 64 → normal reception.
- Long response: long_resp=1, 136-bit frame → `deser_framesize = 136`, `done` at s+136. Also assert `start` at s+10 → it is ignored, with no restart and no `deser_reset`.
- Reset at s+20 → IDLE next cycle, `busy`/flags 0. A new start followed by a valid short frame completes cleanly.
